// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared types for the HPDcache MSHR and its controller.
//   - request field types (cache line, transaction id, source id, word index)
//   - MSHR set/tag/way types and helpers that split a cache line into set and tag
//   - mshr_rsp_status_e: result reported to the miss handler (ALLOC/HIT/FULL)
//   - mshr_ctrl_state_e: controller FSM states
//   - mshr_miss_req_t: captured miss request
package hpdcache_pkg;

    localparam int unsigned HpdcacheNlineWidth = 10;
    localparam int unsigned HpdcacheTidWidth   = 4;
    localparam int unsigned HpdcacheSidWidth   = 2;
    localparam int unsigned HpdcacheWordWidth  = 3;

    localparam int unsigned MshrSetWidth = 2;
    localparam int unsigned MshrWayWidth = 2;
    localparam int unsigned MshrTagWidth = HpdcacheNlineWidth - MshrSetWidth;

    typedef logic [HpdcacheNlineWidth-1:0] hpdcache_nline_t;
    typedef logic [HpdcacheTidWidth-1:0]   hpdcache_req_tid_t;
    typedef logic [HpdcacheSidWidth-1:0]   hpdcache_req_sid_t;
    typedef logic [HpdcacheWordWidth-1:0]  hpdcache_word_t;

    typedef logic [MshrSetWidth-1:0] mshr_set_t;
    typedef logic [MshrTagWidth-1:0] mshr_tag_t;
    typedef logic [MshrWayWidth-1:0] mshr_way_t;

    typedef enum logic [1:0] {
        MshrRspAlloc = 2'd0,
        MshrRspHit   = 2'd1,
        MshrRspFull  = 2'd2
    } mshr_rsp_status_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEval   = 2'd1,
        StAckRsp = 2'd2
    } mshr_ctrl_state_e;

    typedef struct packed {
        hpdcache_nline_t   nline;
        hpdcache_req_tid_t req_id;
        hpdcache_req_sid_t src_id;
        hpdcache_word_t    word;
        logic              need_rsp;
        logic              is_prefetch;
    } mshr_miss_req_t;

    // Low bits of the cache line index the MSHR set, the rest form the tag.
    function automatic mshr_set_t mshr_set_of(hpdcache_nline_t nline);
        return nline[MshrSetWidth-1:0];
    endfunction

    function automatic mshr_tag_t mshr_tag_of(hpdcache_nline_t nline);
        return nline[HpdcacheNlineWidth-1:MshrSetWidth];
    endfunction

endpackage

// File: rtl/hpdcache_mshr_ctrl_arb.sv
// hpdcache_mshr_ctrl_arb: two-way arbiter (miss vs refill ack) with a starvation guard.
// Ack has priority, but after ACK_STREAK_MAX consecutive ack grants while a miss waits,
// the waiting miss is granted.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   enable_i         arbitration allowed this cycle (controller idle)
//   miss_valid_i     miss requester valid
//   ack_valid_i      ack requester valid
//   grant_miss_o     miss granted this cycle
//   grant_ack_o      ack granted this cycle
module hpdcache_mshr_ctrl_arb #(
    parameter int unsigned ACK_STREAK_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic miss_valid_i,
    input  logic ack_valid_i,
    output logic grant_miss_o,
    output logic grant_ack_o
);

    localparam int unsigned StreakW =
        (ACK_STREAK_MAX > 0) ? $clog2(ACK_STREAK_MAX + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(ACK_STREAK_MAX);

    logic [StreakW-1:0] streak;
    logic               miss_starved;

    assign miss_starved = miss_valid_i && (streak == StreakMax);

    always_comb begin
        grant_ack_o  = 1'b0;
        grant_miss_o = 1'b0;
        if (enable_i) begin
            grant_ack_o  = ack_valid_i && !miss_starved;
            grant_miss_o = miss_valid_i && !grant_ack_o;
        end
    end

    // Counts only acks that overtook a waiting miss; any gap in the miss request resets it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak <= '0;
        end else if (!miss_valid_i || grant_miss_o) begin
            streak <= '0;
        end else if (grant_ack_o && (streak != StreakMax)) begin
            streak <= streak + StreakW'(1);
        end
    end

endmodule

// File: rtl/hpdcache_mshr_ctrl.sv
// hpdcache_mshr_ctrl: sequencer/arbiter sharing the single-ported MSHR between the miss
// path (atomic check-then-allocate) and the refill path (acknowledge/release).
// Optional macro HPDCACHE_MSHR_CTRL_STATS_EN adds saturating HIT/FULL/ALLOC counters.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   miss_*_i / miss_ready_o           miss request (valid/ready) and its fields
//   miss_rsp_*_o                      one-cycle result pulse: status, set, way
//   ack_*_i / ack_ready_o             refill ack request (valid/ready), slot to release
//   ack_rsp_valid_o                   pulse one cycle after the ack grant
//   mshr_check_*_o, mshr_hit_i,       MSHR check port and its results
//   mshr_alloc_full_i
//   mshr_alloc_*_o, mshr_alloc_way_i  MSHR alloc port (fields from the capture register)
//   mshr_ack_*_o                      MSHR ack port
//   busy_o                            controller not idle
//   stat_*_o                          outcome counters (stats build only)
module hpdcache_mshr_ctrl
    import hpdcache_pkg::*;
#(
    parameter int unsigned ACK_STREAK_MAX = 4
`ifdef HPDCACHE_MSHR_CTRL_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  hpdcache_nline_t   miss_nline_i,
    input  hpdcache_req_tid_t miss_req_id_i,
    input  hpdcache_req_sid_t miss_src_id_i,
    input  hpdcache_word_t    miss_word_i,
    input  logic              miss_need_rsp_i,
    input  logic              miss_is_prefetch_i,

    output logic              miss_rsp_valid_o,
    output logic [1:0]        miss_rsp_status_o,
    output mshr_set_t         miss_rsp_set_o,
    output mshr_way_t         miss_rsp_way_o,

    input  logic              ack_valid_i,
    output logic              ack_ready_o,
    input  mshr_set_t         ack_set_i,
    input  mshr_way_t         ack_way_i,
    output logic              ack_rsp_valid_o,

    output logic              mshr_check_o,
    output mshr_set_t         mshr_check_set_o,
    output mshr_tag_t         mshr_check_tag_o,
    input  logic              mshr_hit_i,
    input  logic              mshr_alloc_full_i,

    output logic              mshr_alloc_o,
    output logic              mshr_alloc_cs_o,
    output hpdcache_nline_t   mshr_alloc_nline_o,
    output hpdcache_req_tid_t mshr_alloc_req_id_o,
    output hpdcache_req_sid_t mshr_alloc_src_id_o,
    output hpdcache_word_t    mshr_alloc_word_o,
    output logic              mshr_alloc_need_rsp_o,
    output logic              mshr_alloc_is_prefetch_o,
    input  mshr_way_t         mshr_alloc_way_i,

    output logic              mshr_ack_o,
    output logic              mshr_ack_cs_o,
    output mshr_set_t         mshr_ack_set_o,
    output mshr_way_t         mshr_ack_way_o,

    output logic              busy_o
`ifdef HPDCACHE_MSHR_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_hit_o,
    output logic [STAT_WIDTH-1:0] stat_full_o,
    output logic [STAT_WIDTH-1:0] stat_alloc_o
`endif
);

    mshr_ctrl_state_e state, state_next;
    mshr_miss_req_t   miss_cap;
    logic             grant_miss, grant_ack;

    hpdcache_mshr_ctrl_arb #(
        .ACK_STREAK_MAX (ACK_STREAK_MAX)
    ) u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     ((state == StIdle) && !rst_i),
        .miss_valid_i (miss_valid_i),
        .ack_valid_i  (ack_valid_i),
        .grant_miss_o (grant_miss),
        .grant_ack_o  (grant_ack)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_cap <= '0;
        end else if (grant_miss) begin
            miss_cap <= '{
                nline:       miss_nline_i,
                req_id:      miss_req_id_i,
                src_id:      miss_src_id_i,
                word:        miss_word_i,
                need_rsp:    miss_need_rsp_i,
                is_prefetch: miss_is_prefetch_i
            };
        end
    end

    // Every output is gated by reset so a reset cycle never leaks a strobe or a pulse.
    always_comb begin
        state_next               = state;
        miss_ready_o             = 1'b0;
        miss_rsp_valid_o         = 1'b0;
        miss_rsp_status_o        = 2'd0;
        miss_rsp_set_o           = '0;
        miss_rsp_way_o           = '0;
        ack_ready_o              = 1'b0;
        ack_rsp_valid_o          = 1'b0;
        mshr_check_o             = 1'b0;
        mshr_check_set_o         = '0;
        mshr_check_tag_o         = '0;
        mshr_alloc_o             = 1'b0;
        mshr_alloc_cs_o          = 1'b0;
        mshr_alloc_nline_o       = '0;
        mshr_alloc_req_id_o      = '0;
        mshr_alloc_src_id_o      = '0;
        mshr_alloc_word_o        = '0;
        mshr_alloc_need_rsp_o    = 1'b0;
        mshr_alloc_is_prefetch_o = 1'b0;
        mshr_ack_o               = 1'b0;
        mshr_ack_cs_o            = 1'b0;
        mshr_ack_set_o           = '0;
        mshr_ack_way_o           = '0;
        busy_o                   = 1'b0;

        if (!rst_i) begin
            busy_o = (state != StIdle);
            unique case (state)
                StIdle: begin
                    if (grant_ack) begin
                        ack_ready_o    = 1'b1;
                        mshr_ack_o     = 1'b1;
                        mshr_ack_cs_o  = 1'b1;
                        mshr_ack_set_o = ack_set_i;
                        mshr_ack_way_o = ack_way_i;
                        state_next     = StAckRsp;
                    end else if (grant_miss) begin
                        miss_ready_o     = 1'b1;
                        mshr_check_o     = 1'b1;
                        mshr_check_set_o = mshr_set_of(miss_nline_i);
                        mshr_check_tag_o = mshr_tag_of(miss_nline_i);
                        state_next       = StEval;
                    end
                end
                // No ready here: nothing can be granted between check and alloc.
                StEval: begin
                    miss_rsp_valid_o = 1'b1;
                    if (mshr_hit_i) begin
                        miss_rsp_status_o = MshrRspHit;
                    end else if (mshr_alloc_full_i) begin
                        miss_rsp_status_o = MshrRspFull;
                    end else begin
                        miss_rsp_status_o        = MshrRspAlloc;
                        miss_rsp_set_o           = mshr_set_of(miss_cap.nline);
                        miss_rsp_way_o           = mshr_alloc_way_i;
                        mshr_alloc_o             = 1'b1;
                        mshr_alloc_cs_o          = 1'b1;
                        mshr_alloc_nline_o       = miss_cap.nline;
                        mshr_alloc_req_id_o      = miss_cap.req_id;
                        mshr_alloc_src_id_o      = miss_cap.src_id;
                        mshr_alloc_word_o        = miss_cap.word;
                        mshr_alloc_need_rsp_o    = miss_cap.need_rsp;
                        mshr_alloc_is_prefetch_o = miss_cap.is_prefetch;
                    end
                    state_next = StIdle;
                end
                StAckRsp: begin
                    ack_rsp_valid_o = 1'b1;
                    state_next      = StIdle;
                end
                default: begin
                    state_next = StIdle;
                end
            endcase
        end
    end

`ifdef HPDCACHE_MSHR_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] stat_hit, stat_full, stat_alloc;
    logic                  eval_hit, eval_full, eval_alloc;

    assign eval_hit   = miss_rsp_valid_o && (miss_rsp_status_o == MshrRspHit);
    assign eval_full  = miss_rsp_valid_o && (miss_rsp_status_o == MshrRspFull);
    assign eval_alloc = miss_rsp_valid_o && (miss_rsp_status_o == MshrRspAlloc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit   <= '0;
            stat_full  <= '0;
            stat_alloc <= '0;
        end else begin
            if (eval_hit && (stat_hit != '1)) begin
                stat_hit <= stat_hit + STAT_WIDTH'(1);
            end
            if (eval_full && (stat_full != '1)) begin
                stat_full <= stat_full + STAT_WIDTH'(1);
            end
            if (eval_alloc && (stat_alloc != '1)) begin
                stat_alloc <= stat_alloc + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_hit_o   = stat_hit;
    assign stat_full_o  = stat_full;
    assign stat_alloc_o = stat_alloc;
`endif

endmodule

// File: tb/tb_hpdcache_mshr_ctrl.sv
// Bench for hpdcache_mshr_ctrl: directed scenarios with literal expectations, then random
// miss/ack traffic compared every cycle against a transaction-level model.
module tb_hpdcache_mshr_ctrl;
    import hpdcache_pkg::*;

    localparam int StreakMax = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              miss_valid, miss_ready;
    hpdcache_nline_t   miss_nline;
    hpdcache_req_tid_t miss_req_id;
    hpdcache_req_sid_t miss_src_id;
    hpdcache_word_t    miss_word;
    logic              miss_need_rsp, miss_is_prefetch;
    logic              miss_rsp_valid;
    logic [1:0]        miss_rsp_status;
    mshr_set_t         miss_rsp_set;
    mshr_way_t         miss_rsp_way;
    logic              ack_valid, ack_ready, ack_rsp_valid;
    mshr_set_t         ack_set;
    mshr_way_t         ack_way;
    logic              mshr_check, mshr_hit, mshr_alloc_full;
    mshr_set_t         mshr_check_set;
    mshr_tag_t         mshr_check_tag;
    logic              mshr_alloc, mshr_alloc_cs;
    hpdcache_nline_t   al_nline;
    hpdcache_req_tid_t al_req_id;
    hpdcache_req_sid_t al_src_id;
    hpdcache_word_t    al_word;
    logic              al_need_rsp, al_is_prefetch;
    mshr_way_t         mshr_alloc_way;
    logic              mshr_ack, mshr_ack_cs;
    mshr_set_t         mshr_ack_set;
    mshr_way_t         mshr_ack_way;
    logic              busy;
`ifdef HPDCACHE_MSHR_CTRL_STATS_EN
    logic [31:0]       stat_hit, stat_full, stat_alloc;
`endif

    hpdcache_mshr_ctrl #(
        .ACK_STREAK_MAX (StreakMax)
    ) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .miss_valid_i             (miss_valid),
        .miss_ready_o             (miss_ready),
        .miss_nline_i             (miss_nline),
        .miss_req_id_i            (miss_req_id),
        .miss_src_id_i            (miss_src_id),
        .miss_word_i              (miss_word),
        .miss_need_rsp_i          (miss_need_rsp),
        .miss_is_prefetch_i       (miss_is_prefetch),
        .miss_rsp_valid_o         (miss_rsp_valid),
        .miss_rsp_status_o        (miss_rsp_status),
        .miss_rsp_set_o           (miss_rsp_set),
        .miss_rsp_way_o           (miss_rsp_way),
        .ack_valid_i              (ack_valid),
        .ack_ready_o              (ack_ready),
        .ack_set_i                (ack_set),
        .ack_way_i                (ack_way),
        .ack_rsp_valid_o          (ack_rsp_valid),
        .mshr_check_o             (mshr_check),
        .mshr_check_set_o         (mshr_check_set),
        .mshr_check_tag_o         (mshr_check_tag),
        .mshr_hit_i               (mshr_hit),
        .mshr_alloc_full_i        (mshr_alloc_full),
        .mshr_alloc_o             (mshr_alloc),
        .mshr_alloc_cs_o          (mshr_alloc_cs),
        .mshr_alloc_nline_o       (al_nline),
        .mshr_alloc_req_id_o      (al_req_id),
        .mshr_alloc_src_id_o      (al_src_id),
        .mshr_alloc_word_o        (al_word),
        .mshr_alloc_need_rsp_o    (al_need_rsp),
        .mshr_alloc_is_prefetch_o (al_is_prefetch),
        .mshr_alloc_way_i         (mshr_alloc_way),
        .mshr_ack_o               (mshr_ack),
        .mshr_ack_cs_o            (mshr_ack_cs),
        .mshr_ack_set_o           (mshr_ack_set),
        .mshr_ack_way_o           (mshr_ack_way),
        .busy_o                   (busy)
`ifdef HPDCACHE_MSHR_CTRL_STATS_EN
        ,
        .stat_hit_o               (stat_hit),
        .stat_full_o              (stat_full),
        .stat_alloc_o             (stat_alloc)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: a granted miss owes one result next cycle, a granted ack owes
    // one ack pulse next cycle; while a result is owed nothing new can be granted.
    bit  chk_on = 1'b0;
    bit  owe_miss = 1'b0, owe_ack = 1'b0;
    int  acks_over_miss = 0;
    int  m_nline, m_tid, m_sid, m_word, m_need, m_pf;
    bit  g_miss = 1'b0, g_ack = 1'b0;
    int  n_grant = 0, n_rsp = 0, n_drop = 0;

    always @(negedge clk) begin : compare
        bit e_mready, e_aready, e_rsp, e_arsp, e_check, e_alloc, e_ack, e_busy;
        int e_status, e_rset, e_rway, e_cset, e_ctag, e_aset, e_away;
        if (chk_on) begin
            e_mready = 0; e_aready = 0; e_rsp = 0; e_arsp = 0;
            e_check = 0; e_alloc = 0; e_ack = 0; e_busy = 0;
            e_status = 0; e_rset = 0; e_rway = 0; e_cset = 0; e_ctag = 0;
            e_aset = 0; e_away = 0;
            if (!rst) begin
                if (owe_miss) begin
                    e_busy = 1; e_rsp = 1;
                    e_status = mshr_hit ? 1 : (mshr_alloc_full ? 2 : 0);
                    if (e_status == 0) begin
                        e_alloc = 1;
                        e_rset  = m_nline % 4;
                        e_rway  = int'(mshr_alloc_way);
                    end
                end else if (owe_ack) begin
                    e_busy = 1; e_arsp = 1;
                end else if (ack_valid && !(miss_valid && acks_over_miss == StreakMax)) begin
                    e_aready = 1; e_ack = 1;
                    e_aset = int'(ack_set); e_away = int'(ack_way);
                end else if (miss_valid) begin
                    e_mready = 1; e_check = 1;
                    e_cset = int'(miss_nline) % 4; e_ctag = int'(miss_nline) / 4;
                end
            end

            chk("miss_ready", miss_ready, e_mready);
            chk("ack_ready", ack_ready, e_aready);
            chk("miss_rsp_valid", miss_rsp_valid, e_rsp);
            chk("ack_rsp_valid", ack_rsp_valid, e_arsp);
            chk("mshr_check", mshr_check, e_check);
            chk("mshr_alloc", mshr_alloc, e_alloc);
            chk("mshr_alloc_cs", mshr_alloc_cs, e_alloc);
            chk("mshr_ack", mshr_ack, e_ack);
            chk("mshr_ack_cs", mshr_ack_cs, e_ack);
            chk("busy", busy, e_busy);
            chk("strobe_excl", 32'($countones({mshr_check, mshr_alloc, mshr_ack}) > 1), 0);
            if (rst || e_rsp) chk("rsp_status", miss_rsp_status, e_status);
            if (rst || e_alloc) begin
                chk("rsp_set", miss_rsp_set, e_rset);
                chk("rsp_way", miss_rsp_way, e_rway);
                chk("alloc_nline", al_nline, rst ? 0 : m_nline);
                chk("alloc_tid", al_req_id, rst ? 0 : m_tid);
                chk("alloc_sid", al_src_id, rst ? 0 : m_sid);
                chk("alloc_word", al_word, rst ? 0 : m_word);
                chk("alloc_need", al_need_rsp, rst ? 0 : m_need);
                chk("alloc_pf", al_is_prefetch, rst ? 0 : m_pf);
            end
            if (rst || e_check) begin
                chk("check_set", mshr_check_set, e_cset);
                chk("check_tag", mshr_check_tag, e_ctag);
            end
            if (rst || e_ack) begin
                chk("ack_set", mshr_ack_set, e_aset);
                chk("ack_way", mshr_ack_way, e_away);
            end

            if (miss_rsp_valid) n_rsp++;
            if (ack_rsp_valid) n_rsp++;
            g_miss = e_mready;
            g_ack  = e_aready;
            if (rst) begin
                if (owe_miss || owe_ack) n_drop++;
                owe_miss = 0; owe_ack = 0; acks_over_miss = 0;
            end else begin
                owe_miss = e_mready;
                owe_ack  = e_aready;
                if (e_mready || e_aready) n_grant++;
                if (e_mready) begin
                    m_nline = int'(miss_nline); m_tid = int'(miss_req_id);
                    m_sid = int'(miss_src_id); m_word = int'(miss_word);
                    m_need = int'(miss_need_rsp); m_pf = int'(miss_is_prefetch);
                end
                if (!miss_valid || e_mready) acks_over_miss = 0;
                else if (e_aready && acks_over_miss < StreakMax) acks_over_miss++;
            end
        end
    end

    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic new_miss();
        miss_valid = 1'b1;
        miss_nline = hpdcache_nline_t'($urandom);
        miss_req_id = hpdcache_req_tid_t'($urandom);
        miss_src_id = hpdcache_req_sid_t'($urandom);
        miss_word = hpdcache_word_t'($urandom);
        miss_need_rsp = 1'($urandom);
        miss_is_prefetch = 1'($urandom);
    endtask

    task automatic new_ack();
        ack_valid = 1'b1;
        ack_set = mshr_set_t'($urandom);
        ack_way = mshr_way_t'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        miss_valid = 0; miss_nline = '0; miss_req_id = '0; miss_src_id = '0;
        miss_word = '0; miss_need_rsp = 0; miss_is_prefetch = 0;
        ack_valid = 0; ack_set = '0; ack_way = '0;
        mshr_hit = 0; mshr_alloc_full = 0; mshr_alloc_way = '0;
        chk_on = 1'b1;
        repeat (3) nxt();
        rst = 1'b0;
        half();
        chk("reset_busy", busy, 0);
        chk("reset_rsp", miss_rsp_valid, 0);

        // Miss on an empty MSHR
        nxt();
        miss_valid = 1; miss_nline = 10'h2A5; miss_req_id = 4'h7; miss_src_id = 2'h1;
        miss_word = 3'h5; miss_need_rsp = 1; miss_is_prefetch = 0;
        mshr_alloc_way = 2'd2;
        half();
        chk("d1_ready", miss_ready, 1);
        chk("d1_check", mshr_check, 1);
        chk("d1_cset", mshr_check_set, 1);
        chk("d1_ctag", mshr_check_tag, 'hA9);
        chk("d1_no_alloc", mshr_alloc, 0);
        nxt();
        miss_valid = 0;
        half();
        chk("d1_alloc", mshr_alloc, 1);
        chk("d1_rsp", miss_rsp_valid, 1);
        chk("d1_status", miss_rsp_status, 0);
        chk("d1_way", miss_rsp_way, 2);
        chk("d1_set", miss_rsp_set, 1);
        chk("d1_eval_ready", miss_ready, 0);
        chk("d1_alloc_nline", al_nline, 'h2A5);
        chk("d1_alloc_tid", al_req_id, 7);
        nxt();
        half();
        chk("d1_idle", busy, 0);

        // Hit, then full
        for (int k = 0; k < 2; k++) begin
            nxt();
            miss_valid = 1; miss_nline = 10'h0F3;
            half();
            chk("d23_ready", miss_ready, 1);
            nxt();
            miss_valid = 0;
            mshr_hit = (k == 0); mshr_alloc_full = (k == 1);
            half();
            chk("d23_rsp", miss_rsp_valid, 1);
            chk("d23_status", miss_rsp_status, (k == 0) ? 1 : 2);
            chk("d23_no_alloc", mshr_alloc, 0);
            nxt();
            mshr_hit = 0; mshr_alloc_full = 0;
        end

        // Starvation guard: four acks, then the miss, then acks again
        nxt();
        new_miss();
        new_ack();
        for (int c = 0; c <= 10; c++) begin
            half();
            if (c == 0 || c == 2 || c == 4 || c == 6 || c == 10)
                chk("d4_ack_grant", ack_ready, 1);
            if (c == 8) begin
                chk("d4_miss_grant", miss_ready, 1);
                chk("d4_ack_held", ack_ready, 0);
            end
            nxt();
            if (g_ack) new_ack();
            if (g_miss) new_miss();
        end
        miss_valid = 0; ack_valid = 0;
        repeat (2) nxt();

        // Ack arriving during EVAL
        new_miss();
        half();
        chk("d5_miss_grant", miss_ready, 1);
        nxt();
        miss_valid = 0; ack_valid = 1; ack_set = 2'd3; ack_way = 2'd1;
        half();
        chk("d5_eval_ack_ready", ack_ready, 0);
        nxt();
        half();
        chk("d5_ack_ready", ack_ready, 1);
        chk("d5_mshr_ack", mshr_ack, 1);
        chk("d5_ack_set", mshr_ack_set, 3);
        chk("d5_ack_way", mshr_ack_way, 1);
        nxt();
        ack_valid = 0;
        half();
        chk("d5_ack_rsp", ack_rsp_valid, 1);
        nxt();

        // Reset during EVAL drops the miss silently
        new_miss();
        half();
        chk("d6_miss_grant", miss_ready, 1);
        nxt();
        miss_valid = 0; rst = 1;
        half();
        chk("d6_rst_rsp", miss_rsp_valid, 0);
        chk("d6_rst_alloc", mshr_alloc, 0);
        nxt();
        rst = 0;
        half();
        chk("d6_after_busy", busy, 0);
        chk("d6_after_rsp", miss_rsp_valid, 0);
        chk("d6_after_alloc", mshr_alloc, 0);
        nxt();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (!miss_valid || g_miss) begin
                if ($urandom_range(0, 9) < 6) new_miss();
                else miss_valid = 0;
            end
            if (!ack_valid || g_ack) begin
                if ($urandom_range(0, 9) < 5) new_ack();
                else ack_valid = 0;
            end
            mshr_hit = ($urandom_range(0, 3) == 0);
            mshr_alloc_full = ($urandom_range(0, 3) == 0);
            mshr_alloc_way = mshr_way_t'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            nxt();
        end
        miss_valid = 0; ack_valid = 0; rst = 0;
        repeat (4) nxt();
        half();
        chk("grant_rsp_balance", n_rsp, n_grant - n_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
